divider_seq: RTL

DIVIDER_SEQ -- requirements
Module: divider_seq

---
 rtl/divider_seq_if.sv | 25 ++
 rtl/divider_seq.sv | 109 ++++++++++
 2 files changed

// File: rtl/divider_seq_if.sv
// Request/result bundle for the sequential restoring divider.
// A request is taken only while the divider is idle and start=1; done pulses one cycle when results are valid.
interface divider_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             divByZero;
    logic [1:0]       state;

    modport master (
        output start, dataA, dataB,
        input  busy, done, quotient, remainder, divByZero, state
    );

    modport slave (
        input  start, dataA, dataB,
        output busy, done, quotient, remainder, divByZero, state
    );
endinterface

// File: rtl/divider_seq.sv
// Unsigned restoring divider: one quotient bit per cycle, WIDTH cycles per operation.
// A zero divisor skips the iteration and reports all-ones / dividend with divByZero set.
module divider_seq #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    divider_seq_if.slave    bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] q;
    logic [WIDTH:0]   r;
    logic             busy_r;
    logic             done_r;
    logic             dbz_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   diff;
    logic             q_bit;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;

    // Trial subtraction as R' + ~divisor + 1; a clear top bit means the divisor fits.
    always_comb begin
        r_shift = {r[WIDTH-1:0], q[WIDTH-1]};
        diff    = r_shift + ~{1'b0, divisor} + {{WIDTH{1'b0}}, 1'b1};
        q_bit   = ~diff[WIDTH];
        r_next  = q_bit ? diff : r_shift;
        q_next  = {q[WIDTH-2:0], q_bit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            divisor <= '0;
            q       <= '0;
            r       <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dbz_r   <= 1'b0;
            quo_r   <= '0;
            rem_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        divisor <= bus.dataB;
                        q       <= bus.dataA;
                        r       <= '0;
                        cnt     <= '0;
                        if (bus.dataB != '0) begin
                            state  <= RUN;
                            busy_r <= 1'b1;
                        end else begin
                            state  <= DONE;
                            done_r <= 1'b1;
                            quo_r  <= '1;
                            rem_r  <= bus.dataA;
                            dbz_r  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r   <= r_next;
                    q   <= q_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_STEP) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        quo_r  <= q_next;
                        rem_r  <= r_next[WIDTH-1:0];
                        dbz_r  <= 1'b0;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_r <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.quotient  = quo_r;
    assign bus.remainder = rem_r;
    assign bus.divByZero = dbz_r;
    assign bus.state     = state;
endmodule
